// File: rtl/aes_xts_tweak_engine.sv
// aes_xts_tweak_engine
//   XTS whitening/sequencing stage around an external AES-256 core.
//   Loads the encrypted tweak T0 for a sector, whitens each input block with
//   T_j on the way into the core, whitens the core result with the same T_j
//   on the way out, and steps T_{j+1} = T_j * alpha in GF(2^128).
//
//   Ports
//     inClk, inRst                 clock, asynchronous active-high reset
//     inAesMode                    1=encrypt, 0=decrypt (latched on inTweakWr)
//     inTweakWr, inTweakData       start a sector with T0 (honoured in IDLE only)
//     inDataValid/outDataReady     input block handshake, inDataData payload
//     outCoreValid/inCoreReady     whitened block to core, outCoreData/outCoreMode
//     inCoreValid/outCoreReady     core result handshake, inCoreData payload
//     outDataValid/inDataReady     registered output block, outData payload
//     outBusy                      sector in progress
//     outSectorDone                pulse while the last block of the sector is on outData
module aes_xts_tweak_engine #(
    parameter int MAX_INFLIGHT      = 8,
    parameter int BLOCKS_PER_SECTOR = 32
) (
    input  logic         inClk,
    input  logic         inRst,
    input  logic         inAesMode,
    input  logic         inTweakWr,
    input  logic [127:0] inTweakData,
    input  logic         inDataValid,
    output logic         outDataReady,
    input  logic [127:0] inDataData,
    output logic         outCoreValid,
    input  logic         inCoreReady,
    output logic [127:0] outCoreData,
    output logic         outCoreMode,
    input  logic         inCoreValid,
    output logic         outCoreReady,
    input  logic [127:0] inCoreData,
    output logic         outDataValid,
    input  logic         inDataReady,
    output logic [127:0] outData,
    output logic         outBusy,
    output logic         outSectorDone
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = $clog2(BLOCKS_PER_SECTOR + 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(MAX_INFLIGHT);
    localparam logic [CW-1:0] LAST_CNT = CW'(BLOCKS_PER_SECTOR);

    logic [1:0]    state;
    logic [127:0]  tweak;
    logic          mode;
    logic [CW-1:0] issued;
    logic [CW-1:0] retired;
    logic [CW-1:0] issuedInc;

    // Tweak FIFO: pairs each core result with its tweak purely by issue order.
    logic [127:0]  tweakMem [MAX_INFLIGHT];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW:0]   count;
    logic [PW:0]   countNext;
    logic          fifoFull;
    logic          fifoEmpty;

    logic          issueFire;
    logic          coreFire;

    // Multiply by alpha, IEEE 1619 little-endian byte order.
    function automatic logic [127:0] mulAlpha(input logic [127:0] t);
        logic [127:0] r;
        r      = {t[126:0], 1'b0};
        r[7:0] = r[7:0] ^ (t[127] ? 8'h87 : 8'h00);
        return r;
    endfunction

    assign fifoEmpty     = (count == '0);
    assign outCoreValid  = inDataValid && (state == RUN) && !fifoFull;
    assign outDataReady  = (state == RUN) && !fifoFull && inCoreReady;
    assign issueFire     = inDataValid && outDataReady;
    assign outCoreData   = inDataData ^ tweak;
    assign outCoreMode   = mode;
    assign outCoreReady  = !fifoEmpty && (!outDataValid || inDataReady);
    assign coreFire      = inCoreValid && outCoreReady;
    assign outBusy       = (state != IDLE);
    assign outSectorDone = (state == DRAIN) && (retired == LAST_CNT);
    assign issuedInc     = issued + 1'b1;

    always_comb begin
        countNext = count;
        if (issueFire && !coreFire) begin
            countNext = count + 1'b1;
        end else if (!issueFire && coreFire) begin
            countNext = count - 1'b1;
        end
    end

    always_ff @(posedge inClk) begin
        if (issueFire) begin
            tweakMem[wrPtr] <= tweak;
        end
    end

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state        <= IDLE;
            tweak        <= '0;
            mode         <= 1'b0;
            issued       <= '0;
            retired      <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            fifoFull     <= 1'b0;
            outData      <= '0;
            outDataValid <= 1'b0;
        end else begin
            count    <= countNext;
            // Registered full flag: a same-cycle pop does not reopen the issue path.
            fifoFull <= (countNext == FULL_CNT);

            if (issueFire) begin
                tweak  <= mulAlpha(tweak);
                issued <= issuedInc;
                wrPtr  <= wrPtr + 1'b1;
            end

            if (coreFire) begin
                outData      <= inCoreData ^ tweakMem[rdPtr];
                outDataValid <= 1'b1;
                retired      <= retired + 1'b1;
                rdPtr        <= rdPtr + 1'b1;
            end else if (inDataReady) begin
                outDataValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (inTweakWr) begin
                        state   <= RUN;
                        tweak   <= inTweakData;
                        mode    <= inAesMode;
                        issued  <= '0;
                        retired <= '0;
                    end
                end
                RUN: begin
                    if (issueFire && (issuedInc == LAST_CNT)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (retired == LAST_CNT) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
